// File: rtl/botoes_pkg.sv
`default_nettype none
// ==========================================================================
// botoes_pkg - shared types and sizing helpers for the button conditioner
// Rev 1.0
// ==========================================================================
package botoes_pkg;

  localparam int N_BOTOES_PADRAO = 8;
  localparam int DEBOUNCE_PADRAO = 50000;

  typedef enum logic [1:0] {
    SOLTO        = 2'd0,
    CONF_APERTO  = 2'd1,
    APERTADO     = 2'd2,
    CONF_SOLTURA = 2'd3
  } estado_t;

  // Bits needed to hold 0..max_valor, never less than one.
  function automatic int largura_contador(input int max_valor);
    int w;
    w = $clog2(max_valor + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/botoes_condicionador_if.sv
`default_nettype none
// ==========================================================================
// botoes_if - pin-side and matrix-side signals of the button conditioner
// Rev 1.0
// ==========================================================================
interface botoes_if #(
  parameter int N_BOTOES = 8,
  parameter int CONT_W   = 8
);

  logic [N_BOTOES-1:0] btn_raw;
  logic                habilita;
  logic                limpa_cont;
  logic [N_BOTOES-1:0] pulsos;
  logic [CONT_W-1:0]   jogadas;
  logic [N_BOTOES-1:0] db_estavel;
  logic [N_BOTOES-1:0] db_pendente;

  modport master (
    output btn_raw, habilita, limpa_cont,
    input  pulsos, jogadas, db_estavel, db_pendente
  );

  modport slave (
    input  btn_raw, habilita, limpa_cont,
    output pulsos, jogadas, db_estavel, db_pendente
  );

endinterface
`default_nettype wire

// File: rtl/botoes_condicionador_debounce_botao.sv
`default_nettype none
// ==========================================================================
// debounce_botao - 2-FF synchronizer plus debounce FSM for one button
// Optional auto-repeat while held: BOTOES_REPEAT_EN.  Rev 1.0
// ==========================================================================
module debounce_botao
  import botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
`ifdef BOTOES_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 25000000
`endif
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn_raw,
  output logic      evento,
  output logic      estavel
);

  localparam int              CNT_W     = largura_contador(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  estado_t          r_estado;
  logic [CNT_W-1:0] r_cnt;
  logic             r_estavel;
  logic             w_confirma;
  logic             w_repete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The last matching sample of the press window raises the event in the
  // same cycle the FSM commits to APERTADO.
  assign w_confirma = (r_estado == CONF_APERTO) && r_sync2 && (r_cnt == C_ULTIMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado  <= SOLTO;
      r_cnt     <= '0;
      r_estavel <= 1'b0;
    end else begin
      case (r_estado)
        SOLTO: begin
          if (r_sync2) begin
            r_estado <= CONF_APERTO;
            r_cnt    <= CNT_W'(1);
          end
        end
        CONF_APERTO: begin
          if (!r_sync2) begin
            r_estado <= SOLTO;
            r_cnt    <= '0;
          end else if (r_cnt == C_ULTIMO) begin
            r_estado  <= APERTADO;
            r_estavel <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        APERTADO: begin
          if (!r_sync2) begin
            r_estado <= CONF_SOLTURA;
            r_cnt    <= CNT_W'(1);
          end
        end
        CONF_SOLTURA: begin
          if (r_sync2) begin
            r_estado <= APERTADO;
            r_cnt    <= '0;
          end else if (r_cnt == C_ULTIMO) begin
            r_estado  <= SOLTO;
            r_estavel <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_estado  <= SOLTO;
          r_cnt     <= '0;
          r_estavel <= 1'b0;
        end
      endcase
    end
  end

`ifdef BOTOES_REPEAT_EN
  localparam int               REP_W        = largura_contador(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] C_REP_ULTIMO = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep;

  assign w_repete = (r_estado == APERTADO) && r_sync2 && (r_rep == C_REP_ULTIMO);

  // Held outside APERTADO so every entry starts a fresh repeat interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep <= '0;
    end else if (r_estado != APERTADO || !r_sync2 || w_repete) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + REP_W'(1);
    end
  end
`else
  assign w_repete = 1'b0;
`endif

  assign evento  = w_confirma | w_repete;
  assign estavel = r_estavel;

endmodule
`default_nettype wire

// File: rtl/botoes_condicionador.sv
`default_nettype none
// ==========================================================================
// botoes_condicionador - debounced, serialized one-hot toggle pulses from raw
// buttons, with a saturating move counter.  Option: BOTOES_REPEAT_EN.  Rev 1.0
// ==========================================================================
module botoes_condicionador
  import botoes_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
  parameter int CONT_W          = 8,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input wire logic clk,
  input wire logic rst,
  botoes_if.slave  bus
);

  localparam logic [CONT_W-1:0] C_JOG_MAX = '1;

  logic [N_BOTOES-1:0] w_evento;
  logic [N_BOTOES-1:0] w_estavel;
  logic [N_BOTOES-1:0] w_aceitos;
  logic [N_BOTOES-1:0] w_sel;
  logic [N_BOTOES-1:0] r_pendente;
  logic [N_BOTOES-1:0] r_pulsos;
  logic [CONT_W-1:0]   r_jogadas;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_botao
    debounce_botao #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BOTOES_REPEAT_EN
      ,
      .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (bus.btn_raw[i]),
      .evento  (w_evento[i]),
      .estavel (w_estavel[i])
    );
  end

  assign w_aceitos = bus.habilita ? w_evento : '0;

  // Two's-complement trick isolates the lowest pending bit.
  assign w_sel = r_pendente & (~r_pendente + N_BOTOES'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendente <= '0;
      r_pulsos   <= '0;
      r_jogadas  <= '0;
    end else begin
      // New events are ORed after the issued bit is cleared, so a re-press
      // of the bit being issued stays queued.
      r_pendente <= (r_pendente & ~w_sel) | w_aceitos;
      r_pulsos   <= w_sel;
      if (bus.limpa_cont) begin
        r_jogadas <= '0;
      end else if ((|r_pendente) && (r_jogadas != C_JOG_MAX)) begin
        r_jogadas <= r_jogadas + CONT_W'(1);
      end
    end
  end

  assign bus.pulsos      = r_pulsos;
  assign bus.jogadas     = r_jogadas;
  assign bus.db_estavel  = w_estavel;
  assign bus.db_pendente = r_pendente;

endmodule
`default_nettype wire

// File: doc/botoes_condicionador.md
Name: botoes_condicionador

Overview:
Input-side counterpart of the LED matrix driver: it conditions the 8 raw physical push-buttons into clean, single-cycle toggle commands.
- Each button passes through a 2-FF synchronizer, a per-button debounce FSM and a press-edge detector.
- Confirmed presses are queued and issued as one-hot, one-cycle pulses, at most one per clock. Overlapping button regions can therefore never toggle a shared LED in the same cycle.
- Sits between the board pins and the matrix controller's button input; also counts moves for the control unit.

Parameters:
N_BOTOES, 8, number of buttons (the matrix controller uses 8)
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required to accept a level change (minimum 2)
CONT_W, 8, width of the move counter
REPEAT_CYCLES, 25000000, hold time between auto-repeat pulses (used only with BOTOES_REPEAT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_raw  in  N_BOTOES  raw button levels, active-high, asynchronous to clk
habilita  in  1  1 = presses are accepted; 0 = new presses are discarded (e.g. level finished)
limpa_cont  in  1  synchronous clear of jogadas
pulsos  out  N_BOTOES  one-hot (or zero) one-cycle toggle command to the matrix
jogadas  out  CONT_W  number of pulses issued, saturating
db_estavel  out  N_BOTOES  debounced level of each button
db_pendente  out  N_BOTOES  pending-press register

Behaviour:
- Reset (async, rst=1): sync FFs, debounce counters and FSMs clear to SOLTO; pulsos=0, jogadas=0, db_estavel=0, db_pendente=0. Reset mid-debounce or mid-press discards all pending work. A button held through reset release must go through a full debounce before it counts; no pulse is issued for a held button at reset release.
- Sync: 2 flip-flops per bit. The debounce FSM sees the sample s = sync2.
- Per-button FSM, counter width = clog2(DEBOUNCE_CYCLES+1):
  - SOLTO: when s=1, counter is loaded with 1 and the FSM goes to CONF_APERTO.
  - CONF_APERTO: s=1 increments the counter; s=0 returns to SOLTO (counter cleared). When the counter reaches DEBOUNCE_CYCLES, the FSM goes to APERTADO, db_estavel bit becomes 1, and a press event is raised that cycle.
  - APERTADO: s=0 goes to CONF_SOLTURA with counter=1.
  - CONF_SOLTURA: symmetric to CONF_APERTO. Reaching the count goes to SOLTO with db_estavel=0; s=1 returns to APERTADO.
- Press event: if habilita=1, the corresponding db_pendente bit is set; if habilita=0, the event is dropped. A release never generates an event.
- Issue stage, once per cycle:
  - If db_pendente≠0, pulsos gets the one-hot of the lowest-index pending bit, that bit is cleared, and jogadas is incremented.
  - Otherwise pulsos=0.
  - pulsos is registered.
- Latency: a glitch-free press at cycle 0 gives the event at cycle 2+DEBOUNCE_CYCLES and pulsos at the next edge. The pulse is therefore visible 3+DEBOUNCE_CYCLES cycles after the raw edge, plus queueing delay from lower-index pending bits.
- Simultaneous events:
  - Several buttons confirming in the same cycle are issued on consecutive cycles in index order.
  - A new event for a bit that is being issued in the same cycle keeps the bit set, so the second press is issued later.
  - An event for a bit that is already pending (not being issued) is absorbed, giving at most one queued press per button.
- habilita falling to 0: already pending presses are still issued; only new events are blocked.
- jogadas saturates at 2^CONT_W−1. limpa_cont has priority over increment; a pulse in the same cycle as limpa_cont is still issued but not counted.

Optional Feature:
BOTOES_REPEAT_EN
- Defined: in APERTADO, a second counter runs. Every REPEAT_CYCLES cycles while the button is held, it raises an additional press event, subject to the same habilita and queue rules. The counter restarts on entry to APERTADO.
- Undefined: exactly one event per debounced press; no repeat counter is synthesized.

Decomposition:
- Shared package botoes_pkg holds:
  - the debounce state enum (SOLTO, CONF_APERTO, APERTADO, CONF_SOLTURA);
  - default N_BOTOES/DEBOUNCE_CYCLES constants;
  - a clog2-based counter-width function.
- One natural sub-module, debounce_botao: single-bit synchronizer, FSM and counter, instantiated N_BOTOES times. The top holds the pending queue, priority issue logic and counter.

Test Plan:
- Clean press on btn_raw[3] (DEBOUNCE_CYCLES=4) held for 20 cycles -> pulsos=8'h08 for exactly 1 cycle, 7 cycles after the raw edge; jogadas=1; none on release.
- btn_raw[0] toggles every 2 cycles for 30 cycles, then holds 1 -> exactly one pulse 8'h01, after the level is stable for the full debounce window.
- btn_raw[2] and btn_raw[3] rise in the same cycle -> pulsos=8'h04, then 8'h08 on the next cycle; never both set; jogadas=2.
- habilita=0 during a press of btn_raw[5] -> no pulse, db_estavel[5]=1; habilita=1 while still held -> still no pulse until release and a new press.
- rst asserted mid-CONF_APERTO and with a pending bit -> all outputs 0 immediately; held button gives a pulse only after a fresh debounce; jogadas=0.
- jogadas at 255 plus one press -> stays 255; limpa_cont with a simultaneous pulse -> pulse issued, jogadas=0. With BOTOES_REPEAT_EN, REPEAT_CYCLES=10 and a 35-cycle hold -> 1 initial + 3 repeat pulses.
